// File: rtl/clint_mmio_if.sv
// clint_mmio_if: valid/ready request and response channels of the CLINT MMIO port.
interface clint_mmio_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (output req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/clint_mmio.sv
// clint_mmio: single-hart CLINT window (msip, mtimecmp, mtime alias) with a one-deep request/response FSM.
module clint_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          HART_ID   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    clint_mmio_if.slave  bus,
    input  logic [63:0]  mtime_i,
    output logic         mtime_w_en_o,
    output logic [63:0]  mtime_w_data_o,
    output logic         msip_o,
    output logic         mtip_o
);
    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  RESP    = 1'b1;
    localparam logic [15:0] MSIP_OFF = 16'(4 * HART_ID);
    localparam logic [15:0] CLO_OFF  = 16'(32'h4000 + 8 * HART_ID);
    localparam logic [15:0] CHI_OFF  = 16'(32'h4004 + 8 * HART_ID);

    logic [0:0]  state_q, state_d;
    logic        up_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        msip_q;
    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q;
    logic        wen_q;
    logic [63:0] wdata_q, wdata_d;
    logic [15:0] off;
    logic        in_win, is_msip, is_clo, is_chi, is_tlo, is_thi, accept, wr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign bus.req_ready  = up_q && state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign mtime_w_en_o   = wen_q;
    assign mtime_w_data_o = wdata_q;
    assign msip_o         = msip_q;
    assign mtip_o         = mtip_q;

    always_comb begin
        off     = bus.req_addr[15:0];
        in_win  = bus.req_addr[31:16] == BASE_ADDR[31:16];
        is_msip = off == MSIP_OFF;
        is_clo  = off == CLO_OFF;
        is_chi  = off == CHI_OFF;
        is_tlo  = off == 16'hBFF8;
        is_thi  = off == 16'hBFFC;
        err_d   = !in_win || bus.req_addr[1:0] != 2'b00 ||
                  !(is_msip || is_clo || is_chi || is_tlo || is_thi) ||
                  (bus.req_we && bus.req_wstrb == 4'b0000);
        accept  = bus.req_valid && bus.req_ready;
        wr      = accept && bus.req_we && !err_d;
        rdata_d = (err_d || bus.req_we) ? 32'h0 :
                  is_msip ? {31'b0, msip_q} :
                  is_clo  ? cmp_q[31:0] :
                  is_chi  ? cmp_q[63:32] :
                  is_tlo  ? mtime_i[31:0] : mtime_i[63:32];
        cmp_d   = cmp_q;
        if (wr && is_clo) cmp_d[31:0]  = merge(cmp_q[31:0], bus.req_wdata, bus.req_wstrb);
        if (wr && is_chi) cmp_d[63:32] = merge(cmp_q[63:32], bus.req_wdata, bus.req_wstrb);
        wdata_d = is_tlo ? {mtime_i[63:32], merge(mtime_i[31:0], bus.req_wdata, bus.req_wstrb)}
                         : {merge(mtime_i[63:32], bus.req_wdata, bus.req_wstrb), mtime_i[31:0]};
        state_d = accept ? RESP : (state_q == RESP && bus.resp_ready) ? IDLE : state_q;
    end

    // Compare uses the registered mtimecmp, so a compare write shows on mtip one cycle after its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            msip_q  <= 1'b0;
            cmp_q   <= '1;
            mtip_q  <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            up_q    <= 1'b1;
            state_q <= state_d;
            cmp_q   <= cmp_d;
            mtip_q  <= mtime_i >= cmp_q;
            wen_q   <= wr && (is_tlo || is_thi);
            if (accept) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
            if (wr && is_msip && bus.req_wstrb[0]) msip_q <= bus.req_wdata[0];
            if (wr && (is_tlo || is_thi)) wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_clint_mmio.sv
// tb_clint_mmio: directed and randomized checks of clint_mmio against an address-map level model.
module tb_clint_mmio;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] mtime;
    logic        mtime_w_en, msip, mtip;
    logic [63:0] mtime_w_data;
    int          checks = 0;
    int          errors = 0;
    logic        m_msip;
    logic [63:0] m_cmp;

    clint_mmio_if bus();

    clint_mmio #(.BASE_ADDR(BASE), .HART_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mtime_i(mtime),
        .mtime_w_en_o(mtime_w_en), .mtime_w_data_o(mtime_w_data),
        .msip_o(msip), .mtip_o(mtip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: decode by offset, byte-mask merge, mtime write replaces the addressed half.
    task automatic model(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, output logic e_err, output logic [31:0] e_rd,
                         output logic e_wen, output logic [63:0] e_wd);
        logic [31:0] off, mask;
        off  = a - BASE;
        mask = 0;
        for (int i = 0; i < 4; i++) if (ws[i]) mask |= 32'hFF << (8 * i);
        e_err = !(off == 0 || off == 32'h4000 || off == 32'h4004 || off == 32'hBFF8 || off == 32'hBFFC)
                || (we && ws == 0);
        e_rd  = 0;
        e_wen = 0;
        e_wd  = mtime;
        if (!e_err && !we)
            e_rd = off == 0 ? {31'b0, m_msip} : off == 32'h4000 ? m_cmp[31:0] :
                   off == 32'h4004 ? m_cmp[63:32] : off == 32'hBFF8 ? mtime[31:0] : mtime[63:32];
        if (!e_err && we) begin
            if (off == 0 && ws[0]) m_msip = wd[0];
            if (off == 32'h4000) m_cmp[31:0]  = (m_cmp[31:0] & ~mask) | (wd & mask);
            if (off == 32'h4004) m_cmp[63:32] = (m_cmp[63:32] & ~mask) | (wd & mask);
            if (off == 32'hBFF8) begin e_wen = 1; e_wd[31:0]  = (mtime[31:0] & ~mask) | (wd & mask); end
            if (off == 32'hBFFC) begin e_wen = 1; e_wd[63:32] = (mtime[63:32] & ~mask) | (wd & mask); end
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        logic        e_err, e_wen;
        logic [31:0] e_rd;
        logic [63:0] e_wd;
        int          n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.req_ready) begin check("ready_timeout", 0, 1); return; end
        bus.req_valid = 1; bus.req_addr = a; bus.req_we = we; bus.req_wdata = wd; bus.req_wstrb = ws;
        model(a, we, wd, ws, e_err, e_rd, e_wen, e_wd);
        @(posedge clk); #1;
        bus.req_valid = 0;
        check("resp_valid", bus.resp_valid, 1);
        check("ready_busy", bus.req_ready, 0);
        check("rdata", bus.resp_rdata, e_rd);
        check("err", bus.resp_err, e_err);
        check("w_en", mtime_w_en, e_wen);
        if (e_wen) begin
            check("w_data", mtime_w_data, e_wd);
            mtime = e_wd;
        end
        bus.resp_ready = 1;
        @(posedge clk); #1;
        bus.resp_ready = 0;
        check("resp_done", bus.resp_valid, 0);
        check("w_en_pulse", mtime_w_en, 0);
        check("msip", msip, m_msip);
        check("mtip", mtip, mtime >= m_cmp);
    endtask

    task automatic reset_state(input string tag);
        check({tag, "_ready"}, bus.req_ready, 0);
        check({tag, "_rvalid"}, bus.resp_valid, 0);
        check({tag, "_rdata"}, bus.resp_rdata, 0);
        check({tag, "_err"}, bus.resp_err, 0);
        check({tag, "_msip"}, msip, 0);
        check({tag, "_mtip"}, mtip, 0);
        check({tag, "_wen"}, mtime_w_en, 0);
        check({tag, "_wdata"}, mtime_w_data, 0);
    endtask

    task automatic release_reset();
        @(posedge clk); #2;
        rst_n = 1;
        check("ready_pre_edge", bus.req_ready, 0);
        @(posedge clk); #1;
        check("ready_after_reset", bus.req_ready, 1);
    endtask

    initial begin
        logic [31:0] offs[10];
        logic [31:0] a;
        offs = '{32'h0, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC, 32'h4, 32'h8000, 32'h4002, 32'hBFF4, 32'h1_0000};
        rst_n = 0; mtime = 64'd100; m_msip = 0; m_cmp = '1;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_we = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
        bus.resp_ready = 0;
        #1 reset_state("rst");
        repeat (2) @(posedge clk);
        release_reset();
        do_req(BASE + 32'h4000, 0, 0, 0);
        check("clo_reset_val", bus.resp_rdata, 32'hFFFF_FFFF);
        mtime = 64'd1000;
        do_req(BASE + 32'h4004, 1, 0, 4'hF);
        do_req(BASE + 32'h4000, 1, 1000, 4'hF);
        check("mtip_set", mtip, 1);
        do_req(BASE + 32'h4000, 1, 2000, 4'hF);
        check("mtip_clr", mtip, 0);
        do_req(BASE, 1, 1, 4'b0001);
        check("msip_set", msip, 1);
        do_req(BASE, 1, 0, 4'b0010);
        check("msip_keep", msip, 1);
        do_req(BASE, 0, 0, 0);
        check("msip_read", bus.resp_rdata, 1);
        mtime = 64'h1_0000_0005;
        do_req(BASE + 32'hBFF8, 1, 32'h10, 4'hF);
        check("mtime_new", mtime, 64'h1_0000_0010);
        do_req(BASE + 32'h8000, 0, 0, 0);
        check("err_read", bus.resp_err, 1);
        do_req(BASE + 32'h4002, 1, 32'h0, 4'hF);
        check("err_write", bus.resp_err, 1);
        do_req(BASE + 32'h4000, 0, 0, 0);
        check("cmp_untouched", bus.resp_rdata, 2000);
        do_req(BASE + 32'h4000, 1, 32'h1234, 4'h0);
        check("err_nostrb", bus.resp_err, 1);
        for (int k = 0; k < 250; k++) begin
            a = ($urandom_range(7) == 0) ? $urandom : BASE + offs[$urandom_range(9)];
            if ($urandom_range(3) == 0) a[1:0] = 2'($urandom);
            if ($urandom_range(4) == 0) mtime = m_cmp + 64'($signed($urandom_range(6)) - 3);
            else if ($urandom_range(9) == 0) mtime = {$urandom, $urandom};
            do_req(a, 1'($urandom), $urandom, 4'($urandom));
        end
        do_req(BASE, 1, 1, 4'hF);
        bus.req_valid = 1; bus.req_addr = BASE + 32'h4004; bus.req_we = 0;
        @(posedge clk); #1;
        bus.req_valid = 0;
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", bus.resp_valid, 1);
            check("hold_rdata", bus.resp_rdata, m_cmp[63:32]);
            check("hold_ready", bus.req_ready, 0);
            @(posedge clk); #1;
        end
        #2 rst_n = 0;
        #1 reset_state("midrst");
        m_msip = 0; m_cmp = '1; mtime = 64'd100;
        release_reset();
        do_req(BASE + 32'h4004, 0, 0, 0);
        check("chi_after_reset", bus.resp_rdata, 32'hFFFF_FFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clint_mmio.md
CLINT_MMIO -- requirements
Module: clint_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0200_0000, is the byte base address of the CLINT MMIO window, which is 64 KiB.
REQ-002 Parameter HART_ID, default 0, selects this hart's msip word (BASE+4*HART_ID) and mtimecmp pair (BASE+0x4000+8*HART_ID).
REQ-003 clock  in  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  is the asynchronous, active-low reset.
REQ-005 req_valid  in  1  indicates the bus request is valid.
REQ-006 req_ready  out  1  indicates the block accepts a request this cycle.
REQ-007 req_addr  in  32  is the byte address.
REQ-008 req_we  in  1  selects write (1) or read (0).
REQ-009 req_wdata  in  32  is the write data.
REQ-010 req_wstrb  in  4  holds the byte write enables.
REQ-011 resp_valid  out  1  indicates a response is valid.
REQ-012 resp_ready  in  1  indicates the master accepts the response.
REQ-013 resp_rdata  out  32  is the read data; 0 for writes and errors.
REQ-014 resp_err  out  1  flags an access error.
REQ-015 mtime  in  64  is the current value of the time CSR, which mtime aliases.
REQ-016 mtime_w_en  out  1  is a one-cycle request to overwrite the time CSR.
REQ-017 mtime_w_data  out  64  is the new time value, valid while mtime_w_en is 1.
REQ-018 msip  out  1  is the machine software interrupt pending bit, routed to mip.MSIP.
REQ-019 mtip  out  1  is the machine timer interrupt pending bit, routed to mip.MTIP.

Function
REQ-020 Register map (offset from BASE_ADDR): msip at 0x0000+4*HART_ID (bit0 only); mtimecmp_lo at 0x4000+8*HART_ID; mtimecmp_hi at +4; mtime_lo at 0xBFF8; mtime_hi at 0xBFFC.
REQ-021 The FSM SHALL have two states: IDLE and RESP. req_ready=1 only in IDLE. IDLE->RESP on req_valid&&req_ready. RESP->IDLE on resp_ready.
REQ-022 Only one request SHALL be outstanding. resp_valid=1 exactly in RESP, and resp_rdata/resp_err SHALL be held stable until the handshake completes.
REQ-023 Response latency SHALL be 1 cycle: resp_valid rises the cycle after acceptance. Back-to-back accepts are possible no more often than every 2 cycles.
REQ-024 Read data SHALL be sampled in the accept cycle: msip reads {31'b0,msip}; mtimecmp/mtime halves read the corresponding 32 bits.
REQ-025 A write SHALL take effect at the accept-cycle edge, merged bytewise per req_wstrb; msip updates only from wstrb[0], wdata[0].
REQ-026 An mtime write SHALL pulse mtime_w_en for exactly the cycle after accept, with mtime_w_data = mtime sampled in that cycle with the addressed half replaced bytewise per strobe.
REQ-027 The time CSR owner gives mtime_w_en priority over its own increment in the same cycle.
REQ-028 resp_err=1 SHALL be returned if addr outside window, addr[1:0]!=0, offset unmapped, or (write && wstrb==0). Errored writes have no side effect; errored reads return rdata=0.
REQ-029 mtip SHALL be registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated every cycle against the current mtimecmp. mtip therefore reflects an mtimecmp write one cycle after the write edge.
REQ-030 A 32-bit write to one mtimecmp half SHALL leave the other half unchanged; a transient mtip caused between two halves is architecturally permitted.

Reset
REQ-031 While reset=0: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip=0, mtime_w_en=0, mtime_w_data=0.
REQ-032 req_ready SHALL rise the first cycle after reset deasserts. Reset asserted mid-transaction SHALL drop the pending response with no further side effect.

Verification
REQ-033 Read mtimecmp_lo after reset -> resp_valid the next cycle, rdata=32'hFFFF_FFFF, err=0; mtip stays 0 with mtime=100.
REQ-034 With mtime=1000, write mtimecmp_hi=0 then mtimecmp_lo=1000 -> mtip=1 one cycle after the second write edge; then write lo=2000 -> mtip=0 one cycle later.
REQ-035 Write msip with wdata=1, wstrb=4'b0001 -> msip=1; same write with wstrb=4'b0010 -> msip unchanged; read returns 32'h1.
REQ-036 With mtime=64'h1_0000_0005, write mtime_lo=32'h10 with full strobe -> mtime_w_en one cycle later, mtime_w_data=64'h1_0000_0010.
REQ-037 Read BASE+0x8000, and separately write BASE+0x4002 -> resp_err=1, rdata=0, no register change.
REQ-038 Hold resp_ready=0 for 5 cycles after a read -> resp_valid and rdata stable, req_ready=0; assert reset=0 mid-wait -> resp_valid=0 immediately, msip=0.
